// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle for uart_rx_param.
// master: the receiver. It drives the word, the valid/busy status and the error flags.
// slave : the consumer. It drives RXREADY.
//   RXREADY    consumer accepts RXDATA when RXVALID && RXREADY
//   RXDATA     received word, LSB first on the line
//   RXVALID    RXDATA and the flags are valid; held until accepted
//   RXBUSY     frame reception in progress
//   PARITY_ERR parity mismatch on the presented word
//   FRAME_ERR  a stop bit was sampled 0 on the presented word
//   BREAK_DET  line held low for a full frame
//   OVERRUN    sticky; a frame completed while RXVALID was pending
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 RXREADY;
  logic [DATA_BITS-1:0] RXDATA;
  logic                 RXVALID;
  logic                 RXBUSY;
  logic                 PARITY_ERR;
  logic                 FRAME_ERR;
  logic                 BREAK_DET;
  logic                 OVERRUN;

  modport master (
    input  RXREADY,
    output RXDATA, RXVALID, RXBUSY, PARITY_ERR, FRAME_ERR, BREAK_DET, OVERRUN
  );

  modport slave (
    output RXREADY,
    input  RXDATA, RXVALID, RXBUSY, PARITY_ERR, FRAME_ERR, BREAK_DET, OVERRUN
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receive engine.
// It contains a baud divider, mid-bit sampling and configurable data, parity and stop bits.
// It detects parity errors, framing errors, breaks and overruns.
// Ports:
//   CLK    system clock, rising edge
//   RESET  asynchronous active-low reset
//   RX     serial line, idle high, asynchronous to CLK
//   rx_if  master side of the output handshake (word, valid/ready, busy, error flags)
module uart_rx_param #(
  parameter int unsigned DIV         = 868,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            RX,
  uart_rx_param_if.master rx_if
);

  localparam int unsigned CntW = $clog2(DIV);
  localparam int unsigned IdxW = $clog2(DATA_BITS + 3);

  localparam logic [CntW-1:0] HalfLoad = CntW'(DIV / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(DIV - 1);
  localparam logic [IdxW-1:0] LastData = IdxW'(DATA_BITS - 1);
  localparam logic [IdxW-1:0] LastStop = IdxW'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop, StBrk} state_e;

  // Input synchroniser. It is preset to idle-high so that reset cannot fake a start bit.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // Frame engine state
  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  perr_q, perr_d;     // parity error of the frame in flight
  logic                  ferr_q, ferr_d;     // some stop sample of this frame was 0
  logic                  zero_q, zero_d;     // every sample since the start bit was 0
  logic                  busy_q, busy_d;

  // Presented word and flags
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  perr_out_q, perr_out_d;
  logic                  ferr_out_q, ferr_out_d;
  logic                  brk_out_q, brk_out_d;
  logic                  overrun_q, overrun_d;

  logic                  tick;
  logic                  done;
  logic                  frame_err_now;
  logic                  break_now;
  logic                  par_x;

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    perr_d        = perr_q;
    ferr_d        = ferr_q;
    zero_d        = zero_q;
    busy_d        = busy_q;
    data_d        = data_q;
    valid_d       = valid_q;
    perr_out_d    = perr_out_q;
    ferr_out_d    = ferr_out_q;
    brk_out_d     = brk_out_q;
    overrun_d     = overrun_q;
    done          = 1'b0;
    frame_err_now = ferr_q;
    break_now     = 1'b0;
    par_x         = (^shift_q) ^ rxs;

    unique case (state_q)
      StIdle: begin
        if (!rxs) begin
          state_d = StStart;
          cnt_d   = HalfLoad;
          busy_d  = 1'b1;
        end
      end

      StStart: begin
        if (tick) begin
          if (rxs) begin
            // The line went high again before mid-bit, so this was a glitch.
            state_d = StIdle;
            busy_d  = 1'b0;
          end else begin
            state_d = StData;
            cnt_d   = FullLoad;
            idx_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            zero_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StData: begin
        if (tick) begin
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          zero_d  = zero_q & ~rxs;
          cnt_d   = FullLoad;
          if (idx_q == LastData) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? StPar : StStop;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StPar: begin
        if (tick) begin
          // Even parity requires a zero XOR of data and parity bit; odd parity requires a one.
          perr_d  = (PARITY == 2) ? par_x : ~par_x;
          zero_d  = zero_q & ~rxs;
          cnt_d   = FullLoad;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StStop: begin
        if (tick) begin
          frame_err_now = ferr_q | ~rxs;
          break_now     = zero_q & ~rxs;
          ferr_d        = frame_err_now;
          zero_d        = break_now;
          if (idx_q == LastStop) begin
            done  = 1'b1;
            idx_d = '0;
            cnt_d = '0;
            if (break_now) begin
              // Keep busy until the line is released, so a held-low line is not re-armed.
              state_d = StBrk;
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end
          end else begin
            idx_d = idx_q + 1'b1;
            cnt_d = FullLoad;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StBrk: begin
        if (rxs) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase

    // Acceptance clears the word together with its flags.
    if (valid_q && rx_if.RXREADY) begin
      valid_d    = 1'b0;
      perr_out_d = 1'b0;
      ferr_out_d = 1'b0;
      brk_out_d  = 1'b0;
    end

    // A completion that meets an unaccepted word drops the new word.
    // A completion in the same cycle as an acceptance replaces the old word.
    if (done) begin
      if (valid_q && !rx_if.RXREADY) begin
        overrun_d = 1'b1;
      end else begin
        data_d     = shift_q;
        valid_d    = 1'b1;
        perr_out_d = perr_q;
        ferr_out_d = frame_err_now;
        brk_out_d  = break_now;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      zero_q     <= 1'b0;
      busy_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      brk_out_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      zero_q     <= zero_d;
      busy_q     <= busy_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      brk_out_q  <= brk_out_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_if.RXDATA     = data_q;
  assign rx_if.RXVALID    = valid_q;
  assign rx_if.RXBUSY     = busy_q;
  assign rx_if.PARITY_ERR = perr_out_q;
  assign rx_if.FRAME_ERR  = ferr_out_q;
  assign rx_if.BREAK_DET  = brk_out_q;
  assign rx_if.OVERRUN    = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param.
// It runs two instances on a shared line: 8N1 and 7E2, both with DIV=16.
// Monitors log every accepted word with its flags and cycle number.
// Expected words come from frame contents chosen by the bench.
module tb_uart_rx_param;

  localparam int unsigned DIVB = 16;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  logic RX    = 1'b1;
  logic rdy8  = 1'b1;
  logic rdy7  = 1'b1;

  always #5 CLK = ~CLK;

  uart_rx_param_if #(.DATA_BITS(8)) if8 ();
  uart_rx_param_if #(.DATA_BITS(7)) if7 ();

  assign if8.RXREADY = rdy8;
  assign if7.RXREADY = rdy7;

  uart_rx_param #(
    .DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)
  ) u_dut8 (
    .CLK(CLK), .RESET(RESET), .RX(RX), .rx_if(if8)
  );

  uart_rx_param #(
    .DIV(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .SYNC_STAGES(2)
  ) u_dut7 (
    .CLK(CLK), .RESET(RESET), .RX(RX), .rx_if(if7)
  );

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor logs: accepted words, flags {perr, ferr, brk}, acceptance cycle
  logic [8:0]  d8 [256];
  logic [2:0]  f8 [256];
  int unsigned c8 [256];
  int unsigned n8 = 0, vcnt8 = 0, busy_rise8 = 0, last_busy8 = 0;
  logic        busy_prev8 = 1'b0;
  logic [8:0]  d7 [256];
  logic [2:0]  f7 [256];
  int unsigned n7 = 0;

  always @(negedge CLK) begin
    if (if8.RXVALID && if8.RXREADY) begin
      d8[n8[7:0]] <= {1'b0, if8.RXDATA};
      f8[n8[7:0]] <= {if8.PARITY_ERR, if8.FRAME_ERR, if8.BREAK_DET};
      c8[n8[7:0]] <= cyc;
      n8          <= n8 + 1;
    end
    if (if8.RXVALID) vcnt8 <= vcnt8 + 1;
    if (if8.RXBUSY && !busy_prev8) busy_rise8 <= cyc;
    if (if8.RXBUSY) last_busy8 <= cyc;
    busy_prev8 <= if8.RXBUSY;
  end

  always @(negedge CLK) begin
    if (if7.RXVALID && if7.RXREADY) begin
      d7[n7[7:0]] <= {2'b00, if7.RXDATA};
      f7[n7[7:0]] <= {if7.PARITY_ERR, if7.FRAME_ERR, if7.BREAK_DET};
      n7          <= n7 + 1;
    end
  end

  int unsigned n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every wait ends 1 time unit after a rising edge, away from the sampling edge.
  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    RX = b;
    wait_cyc(DIVB);
  endtask

  task automatic send_frame(input logic [8:0] data, input int unsigned nd, input bit has_par,
                            input logic pbit, input int unsigned ns, input logic [1:0] stops);
    send_bit(1'b0);
    for (int i = 0; i < nd; i++) send_bit(data[i]);
    if (has_par) send_bit(pbit);
    for (int i = 0; i < ns; i++) send_bit(stops[i]);
    RX = 1'b1;
  endtask

  task automatic do_reset();
    RX    = 1'b1;
    RESET = 1'b0;
    wait_cyc(2);
    RESET = 1'b1;
    wait_cyc(2);
  endtask

  task automatic chk_rec8(input string tag, input int unsigned k, input logic [8:0] d,
                          input logic [2:0] f);
    chk({tag, "_data"}, 32'(d8[k[7:0]]), 32'(d));
    chk({tag, "_flags"}, 32'(f8[k[7:0]]), 32'(f));
  endtask

  task automatic chk_rec7(input string tag, input int unsigned k, input logic [8:0] d,
                          input logic [2:0] f);
    chk({tag, "_data"}, 32'(d7[k[7:0]]), 32'(d));
    chk({tag, "_flags"}, 32'(f7[k[7:0]]), 32'(f));
  endtask

  typedef struct {
    bit         use7;
    logic [8:0] data;
    logic       pbit;
    logic [1:0] stops;   // bit 0 is the first stop bit on the line
    logic [8:0] exp_d;
    logic [2:0] exp_f;   // {perr, ferr, brk}
  } vec_t;

  vec_t        vecs [10];
  int unsigned base, v0, c0, target;
  logic [8:0]  ed [12];
  logic [2:0]  ef [12];
  logic [7:0]  rd8;
  logic [6:0]  rd7;
  logic        rstop, rinj;

  initial begin
    vecs[0] = '{1'b0, 9'h0A5, 1'b0, 2'b01, 9'h0A5, 3'b000};
    vecs[1] = '{1'b0, 9'h03C, 1'b0, 2'b00, 9'h03C, 3'b010};
    vecs[2] = '{1'b0, 9'h0FF, 1'b0, 2'b01, 9'h0FF, 3'b000};
    vecs[3] = '{1'b0, 9'h000, 1'b0, 2'b00, 9'h000, 3'b011};
    vecs[4] = '{1'b1, 9'h041, 1'b0, 2'b11, 9'h041, 3'b000};
    vecs[5] = '{1'b1, 9'h041, 1'b1, 2'b11, 9'h041, 3'b100};
    vecs[6] = '{1'b1, 9'h07F, 1'b1, 2'b11, 9'h07F, 3'b000};
    vecs[7] = '{1'b1, 9'h07F, 1'b0, 2'b11, 9'h07F, 3'b100};
    vecs[8] = '{1'b1, 9'h02A, 1'b1, 2'b01, 9'h02A, 3'b010};
    vecs[9] = '{1'b1, 9'h000, 1'b0, 2'b00, 9'h000, 3'b011};

    // Reset state
    #2 RESET = 1'b0;
    wait_cyc(2);
    chk("rst_valid8", if8.RXVALID, 1'b0);
    chk("rst_busy8", if8.RXBUSY, 1'b0);
    chk("rst_data8", if8.RXDATA, 8'h00);
    chk("rst_flags8", {if8.PARITY_ERR, if8.FRAME_ERR, if8.BREAK_DET, if8.OVERRUN}, 4'h0);
    chk("rst_valid7", if7.RXVALID, 1'b0);
    chk("rst_busy7", if7.RXBUSY, 1'b0);
    RESET = 1'b1;
    wait_cyc(4);

    // 8N1 0xA5 timing. The synchroniser makes T0 the fall cycle + 2.
    // So busy is seen at fall+3 and valid at fall+155.
    base = n8;
    v0   = vcnt8;
    c0   = cyc;
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1, 2'b01);
    wait_cyc(20);
    chk("a5_busy_rise", busy_rise8, c0 + 3);
    chk("a5_valid_cycles", vcnt8 - v0, 1);
    chk("a5_count", n8 - base, 1);
    chk("a5_valid_at", c8[base[7:0]], c0 + 155);
    chk_rec8("a5", base, 9'h0A5, 3'b000);
    chk("a5_busy_end", if8.RXBUSY, 1'b0);

    // Table-driven frames
    for (int i = 0; i < 10; i++) begin
      do_reset();
      if (vecs[i].use7) begin
        base = n7;
        send_frame(vecs[i].data, 7, 1'b1, vecs[i].pbit, 2, vecs[i].stops);
        wait_cyc(40);
        chk($sformatf("vec%0d_count", i), n7 - base, 1);
        chk_rec7($sformatf("vec%0d", i), base, vecs[i].exp_d, vecs[i].exp_f);
      end else begin
        base = n8;
        send_frame(vecs[i].data, 8, 1'b0, 1'b0, 1, vecs[i].stops);
        wait_cyc(40);
        chk($sformatf("vec%0d_count", i), n8 - base, 1);
        chk_rec8($sformatf("vec%0d", i), base, vecs[i].exp_d, vecs[i].exp_f);
      end
    end

    // A framing error, then a held-low line
    do_reset();
    base = n8;
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1, 2'b00);
    wait_cyc(40);
    chk_rec8("ferr3c", base, 9'h03C, 3'b010);
    base = n8;
    RX   = 1'b0;
    wait_cyc(20 * DIVB);
    chk("brk_busy_held", if8.RXBUSY, 1'b1);
    chk("brk_count", n8 - base, 1);
    chk_rec8("brk", base, 9'h000, 3'b011);
    RX = 1'b1;
    wait_cyc(4);
    chk("brk_busy_release", if8.RXBUSY, 1'b0);
    wait_cyc(40);
    chk("brk_no_extra", n8 - base, 1);

    // Overrun: the second word is dropped and the first is kept
    do_reset();
    rdy8 = 1'b0;
    base = n8;
    send_frame(9'h011, 8, 1'b0, 1'b0, 1, 2'b01);
    send_frame(9'h022, 8, 1'b0, 1'b0, 1, 2'b01);
    wait_cyc(20);
    chk("ovr_valid", if8.RXVALID, 1'b1);
    chk("ovr_data", if8.RXDATA, 8'h11);
    chk("ovr_flag", if8.OVERRUN, 1'b1);
    rdy8 = 1'b1;
    wait_cyc(3);
    chk("ovr_count", n8 - base, 1);
    chk_rec8("ovr_word", base, 9'h011, 3'b000);
    chk("ovr_valid_fall", if8.RXVALID, 1'b0);
    chk("ovr_sticky", if8.OVERRUN, 1'b1);

    // Reset in the middle of the data bits of 0x5A (OVERRUN is still set from above)
    base = n8;
    v0   = vcnt8;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("mid_busy_before", if8.RXBUSY, 1'b1);
    RESET = 1'b0;
    #1;
    chk("mid_rst_busy", if8.RXBUSY, 1'b0);
    chk("mid_rst_valid", if8.RXVALID, 1'b0);
    chk("mid_rst_ovr", if8.OVERRUN, 1'b0);
    chk("mid_rst_flags", {if8.PARITY_ERR, if8.FRAME_ERR, if8.BREAK_DET}, 3'b000);
    RX = 1'b1;
    wait_cyc(3);
    RESET = 1'b1;
    wait_cyc(3);
    send_frame(9'h099, 8, 1'b0, 1'b0, 1, 2'b01);
    wait_cyc(20);
    chk("post_rst_count", n8 - base, 1);
    chk("post_rst_vcycles", vcnt8 - v0, 1);
    chk_rec8("post_rst", base, 9'h099, 3'b000);

    // A 5-cycle glitch is rejected at the half-bit check (T0+8 = fall+10)
    do_reset();
    v0 = vcnt8;
    c0 = cyc;
    RX = 1'b0;
    wait_cyc(5);
    RX = 1'b1;
    wait_cyc(40);
    chk("glitch_busy_rise", busy_rise8, c0 + 3);
    chk("glitch_busy_last", last_busy8, c0 + 10);
    chk("glitch_no_valid", vcnt8 - v0, 0);

    // Back-to-back frames
    do_reset();
    base = n8;
    v0   = vcnt8;
    send_frame(9'h001, 8, 1'b0, 1'b0, 1, 2'b01);
    send_frame(9'h0FF, 8, 1'b0, 1'b0, 1, 2'b01);
    send_frame(9'h080, 8, 1'b0, 1'b0, 1, 2'b01);
    wait_cyc(20);
    chk("b2b_count", n8 - base, 3);
    chk("b2b_vcycles", vcnt8 - v0, 3);
    chk_rec8("b2b0", base, 9'h001, 3'b000);
    chk_rec8("b2b1", base + 1, 9'h0FF, 3'b000);
    chk_rec8("b2b2", base + 2, 9'h080, 3'b000);
    chk("b2b_ovr", if8.OVERRUN, 1'b0);

    // Acceptance in the completion cycle of the next frame (fall of B + 154)
    rdy8   = 1'b0;
    base   = n8;
    c0     = cyc;
    target = c0 + 10 * DIVB + 154;
    fork
      begin
        send_frame(9'h033, 8, 1'b0, 1'b0, 1, 2'b01);
        send_frame(9'h0CC, 8, 1'b0, 1'b0, 1, 2'b01);
      end
      begin
        while (cyc < target) wait_cyc(1);
        rdy8 = 1'b1;
      end
    join
    wait_cyc(20);
    chk("sim_count", n8 - base, 2);
    chk_rec8("sim_a", base, 9'h033, 3'b000);
    chk_rec8("sim_b", base + 1, 9'h0CC, 3'b000);
    chk("sim_a_at", c8[base[7:0]], target);
    chk("sim_b_at", c8[(base + 1) & 8'hFF], target + 1);
    chk("sim_ovr", if8.OVERRUN, 1'b0);

    // Random 8N1 frames. Some have a zero stop bit and get an idle gap after them.
    do_reset();
    base = n8;
    for (int i = 0; i < 12; i++) begin
      rd8   = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      ed[i] = {1'b0, rd8};
      ef[i] = {1'b0, ~rstop, (rd8 == 8'h00) && !rstop};
      send_frame({1'b0, rd8}, 8, 1'b0, 1'b0, 1, {1'b1, rstop});
      if (!rstop) wait_cyc(DIVB + $urandom_range(0, 20));
      else wait_cyc($urandom_range(0, 20));
    end
    wait_cyc(40);
    chk("rnd8_count", n8 - base, 12);
    for (int i = 0; i < 12; i++) chk_rec8($sformatf("rnd8_%0d", i), base + i, ed[i], ef[i]);

    // Random 7E2 frames with some wrong parity bits
    do_reset();
    base = n7;
    for (int i = 0; i < 12; i++) begin
      rd7   = 7'($urandom);
      rinj  = ($urandom_range(0, 3) == 0);
      ed[i] = {2'b00, rd7};
      ef[i] = {rinj, 2'b00};
      send_frame({2'b00, rd7}, 7, 1'b1, (^rd7) ^ rinj, 2, 2'b11);
      wait_cyc($urandom_range(0, 20));
    end
    wait_cyc(40);
    chk("rnd7_count", n7 - base, 12);
    for (int i = 0; i < 12; i++) chk_rec7($sformatf("rnd7_%0d", i), base + i, ed[i], ef[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receive engine, the successor to the fixed 8N1 receiver. It has an integrated baud divider and mid-bit sampling, so no external BCLK or STATE inputs are needed. It supports configurable data width, parity and stop bits, with parity, framing, break and overrun detection. It sits between the pin synchroniser boundary and the RX FIFO / register interface, and uses a valid/ready handshake on the output.

Parameters:
DIV, 868, CLK cycles per bit; integer ≥ 4, even.
DATA_BITS, 8, data bits per frame; 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
SYNC_STAGES, 2, RX input synchroniser flops; ≥ 2.

Ports:
CLK  in  1  system clock
RESET  in  1  reset, asynchronous, active-low
RX  in  1  serial line, idle high, asynchronous to CLK
RXREADY  in  1  consumer accepts RXDATA when RXVALID && RXREADY
RXDATA  out  DATA_BITS  received word, LSB first on the line
RXVALID  out  1  RXDATA/error flags valid; held until accepted
RXBUSY  out  1  frame reception in progress
PARITY_ERR  out  1  parity mismatch on the presented word
FRAME_ERR  out  1  a stop bit was sampled 0 on the presented word
BREAK_DET  out  1  line held low for a full frame
OVERRUN  out  1  sticky; a frame completed while RXVALID was pending

Behaviour:
- Reset (async, RESET = 0): every output is 0; FSM goes to IDLE; counters are 0; synchroniser flops are preset to 1.
- All logic is clocked on CLK rising edge. RX passes through SYNC_STAGES flops; "rxs" below is the synchronised value.
- FSM states: IDLE, START, DATA, PAR, STOP, BRK.
- IDLE → START on the first cycle rxs = 0 (call this T0). The bit counter loads DIV/2−1 and RXBUSY rises at T0+1.
- START: at T0+DIV/2 sample rxs.
  - rxs = 1 → false start; return to IDLE and drop RXBUSY. No flags change.
  - rxs = 0 → go to DATA and reload the counter to DIV−1.
- Sample point k (k = 1..) falls at T0+DIV/2+k·DIV.
- DATA: shift in DATA_BITS samples, LSB first. Then go to PAR if PARITY ≠ 0, otherwise STOP.
- PAR: one sample. For even parity, the XOR of data and parity bit must be 0; for odd parity it must be 1.
- STOP: STOP_BITS samples. Any 0 sets the frame-error condition.
- Completion (last stop sample, cycle Tc) updates the following at Tc+1:
  - RXDATA ← shift register.
  - RXVALID ← 1.
  - PARITY_ERR and FRAME_ERR reflect this frame.
  - BREAK_DET = 1 if all data, parity and stop samples were 0.
  - RXBUSY ← 0, except on break.
- Break: FSM enters BRK and RXBUSY stays 1 until rxs = 1, then returns to IDLE. The next start is accepted only after rxs is seen high.
- Non-break completion: FSM returns to IDLE at Tc+1. A falling edge at Tc+1 or later is a new start.
- Handshake:
  - RXVALID stays 1 and RXDATA and flags stay stable until a cycle with RXVALID && RXREADY.
  - RXVALID clears on the following edge.
  - PARITY_ERR, FRAME_ERR and BREAK_DET are qualified by RXVALID; they clear together with it.
- Overrun: completion while RXVALID = 1 and no acceptance that same cycle →
  - the new word is discarded and the old word is kept;
  - OVERRUN ← 1 (sticky until reset).
- Simultaneous acceptance and completion in the same cycle: the new word loads and RXVALID stays 1. No overrun.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is lost and no RXVALID is produced.
- RX glitch shorter than DIV/2 cycles: rejected by the false-start check.
- Counter width: clog2(DIV). Bit index width: clog2(DATA_BITS+3). No counter wraps outside its load/terminal values.

Test Plan:
- DIV=16, 8N1, send 0xA5 with RXREADY = 1 → RXBUSY at T0+1; RXDATA = 0xA5; RXVALID high for exactly 1 cycle at T0+153; all error flags 0.
- DIV=16, DATA_BITS=7, PARITY=2, STOP_BITS=2, send 0x41 with correct parity 0, then the same word with parity 1 → first: RXDATA = 0x41, PARITY_ERR = 0; second: PARITY_ERR = 1, RXDATA = 0x41.
- 8N1, send 0x3C with stop bit forced 0 → RXVALID = 1, FRAME_ERR = 1, BREAK_DET = 0. Then hold RX low for 20 bit times → BREAK_DET = 1, RXDATA = 0x00, RXBUSY stays 1 until RX returns high, then 0.
- RXREADY = 0, send 0x11 then 0x22 → RXDATA stays 0x11 and OVERRUN = 1. Assert RXREADY → RXVALID falls; OVERRUN stays 1.
- RX low pulse of 5 cycles (DIV=16) → no RXBUSY beyond T0+8, no RXVALID. Separately, assert RESET mid-DATA of 0x5A → all outputs 0 immediately; a following clean frame 0x99 is received correctly.
- Back-to-back frames 0x01, 0xFF, 0x80 with RXREADY = 1 and the next start bit immediately after the stop bit → three RXVALID pulses with the correct data, no flags, and acceptance coinciding with completion causes no overrun.
